// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI master arbiter: FSM encodings, default
// parameters and the pointer-width helper.
package spi_arb_pkg;

    localparam int DEF_N            = 4;
    localparam int DEF_MAX_BURST    = 16;
    localparam int DEF_BUSY_TIMEOUT = 4;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_START     = ST_START,
        S_WAIT_BUSY = ST_WAIT_BUSY,
        S_WAIT_DONE = ST_WAIT_DONE,
        S_ACK       = ST_ACK
    } state_e;

    // Width of an index into n items; never less than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_master_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr,
// wrapping from N-1 back to 0.
module rr_pick
    import spi_arb_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [PW-1:0] idx,
    output logic          any
);

    int j;

    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        j    = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!any && req[j]) begin
                any     = 1'b1;
                pick[j] = 1'b1;
                idx     = PW'(j);
            end
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one SPI master driver between N requesters: round-robin grant,
// start/busy sequencing with a busy timeout, and bounded locked bursts.
module spi_master_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N            = DEF_N,
    parameter int MAX_BURST    = DEF_MAX_BURST,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [N-1:0]   req_bi,
    input  logic [N-1:0]   lock_bi,
    input  logic [N*8-1:0] wdata_bi,
    output logic [N-1:0]   gnt_bo,
    output logic [N-1:0]   ack_bo,
    output logic           err_bo,
    output logic [7:0]     rdata_bo,
    output logic           drv_start_o,
    output logic [7:0]     drv_data_o,
    input  logic           drv_busy_i,
    input  logic [7:0]     drv_data_i,
    output logic [2:0]     state_o
);

    localparam int PW = ptr_width(N);
    localparam int TW = ptr_width(BUSY_TIMEOUT + 1);

    // Handshake: drv_start_o is a one-cycle pulse in START; the driver owns
    // the byte once drv_busy_i rises and the result is valid when it falls.
    state_e          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [7:0]      burst_q, burst_d;
    logic [TW-1:0]   to_q, to_d;
    logic            err_q, err_d;
    logic [7:0]      rdata_q, rdata_d;
    logic [7:0]      dout_q, dout_d;

    logic [N-1:0]    pick;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;

    rr_pick #(.N(N), .PW(PW)) u_rr_pick (
        .req  (req_bi),
        .ptr  (ptr_q),
        .pick (pick),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            burst_q <= '0;
            to_q    <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
            to_q    <= to_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        to_d    = to_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        dout_d  = dout_q;
        case (state_q)
            // A busy driver here means it outlived a controller-only reset.
            S_IDLE: begin
                if (!drv_busy_i && pick_any) begin
                    gnt_d   = pick;
                    gidx_d  = pick_idx;
                    burst_d = 8'd1;
                    dout_d  = wdata_bi[8*int'(pick_idx) +: 8];
                    state_d = S_START;
                end
            end
            S_START: begin
                to_d    = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (drv_busy_i) begin
                    state_d = S_WAIT_DONE;
                end else if (to_q == TW'(BUSY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_ACK;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!drv_busy_i) begin
                    rdata_d = drv_data_i;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                err_d = 1'b0;
                if (lock_bi[gidx_q] && req_bi[gidx_q] && (burst_q < 8'(MAX_BURST))) begin
                    burst_d = burst_q + 8'd1;
                    dout_d  = wdata_bi[8*int'(gidx_q) +: 8];
                    state_d = S_START;
                end else begin
                    gnt_d   = '0;
                    ptr_d   = (gidx_q == PW'(N - 1)) ? '0 : gidx_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign gnt_bo      = gnt_q;
    assign ack_bo      = (state_q == S_ACK) ? gnt_q : '0;
    assign err_bo      = (state_q == S_ACK) && err_q;
    assign rdata_bo    = rdata_q;
    assign drv_start_o = (state_q == S_START);
    assign drv_data_o  = dout_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with a behavioural SPI driver model
// that returns the inverted byte (or a fixed byte) after four busy cycles.
module tb_spi_master_arbiter;

    localparam int N  = 4;
    localparam int MB = 3;
    localparam int BT = 4;

    localparam logic [2:0] E_IDLE      = 3'd0;
    localparam logic [2:0] E_START     = 3'd1;
    localparam logic [2:0] E_WAIT_DONE = 3'd3;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic [N-1:0]   req_bi = '0;
    logic [N-1:0]   lock_bi = '0;
    logic [N*8-1:0] wdata_bi = '0;
    logic [N-1:0]   gnt_bo, ack_bo;
    logic           err_bo;
    logic [7:0]     rdata_bo;
    logic           drv_start_o;
    logic [7:0]     drv_data_o;
    logic           drv_busy_i;
    logic [7:0]     drv_data_i;
    logic [2:0]     state_o;

    int n_checks = 0;
    int n_fail   = 0;

    spi_master_arbiter #(.N(N), .MAX_BURST(MB), .BUSY_TIMEOUT(BT)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_bi      (req_bi),
        .lock_bi     (lock_bi),
        .wdata_bi    (wdata_bi),
        .gnt_bo      (gnt_bo),
        .ack_bo      (ack_bo),
        .err_bo      (err_bo),
        .rdata_bo    (rdata_bo),
        .drv_start_o (drv_start_o),
        .drv_data_o  (drv_data_o),
        .drv_busy_i  (drv_busy_i),
        .drv_data_i  (drv_data_i),
        .state_o     (state_o)
    );

    always #5 clk_i = ~clk_i;

    // Driver model: busy rises the cycle after start and stays high four cycles.
    logic       model_en   = 1'b1;
    logic       use_fixed  = 1'b0;
    logic       hold_busy  = 1'b0;
    logic       model_busy = 1'b0;
    logic [7:0] fixed_rx   = '0;
    logic [7:0] model_rx   = '0;
    int         model_cnt  = 0;

    always @(posedge clk_i) begin
        if (model_busy) begin
            if (model_cnt == 0) model_busy <= 1'b0;
            else                model_cnt  <= model_cnt - 1;
        end else if (model_en && drv_start_o) begin
            model_busy <= 1'b1;
            model_cnt  <= 3;
            model_rx   <= use_fixed ? fixed_rx : ~drv_data_o;
        end
    end

    assign drv_busy_i = model_busy | hold_busy;
    assign drv_data_i = model_rx;

    task automatic apply_reset();
        @(negedge clk_i);
        rst_i     = 1'b1;
        req_bi    = '0;
        lock_bi   = '0;
        hold_busy = 1'b0;
        model_en  = 1'b1;
        use_fixed = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk_i);
            if (drv_start_o) ok = 1'b1;
        end
    endtask

    task automatic wait_ack(output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_i);
            if (ack_bo != '0) begin
                ok  = 1'b1;
                cyc = i + 1;
            end
        end
    endtask

    task automatic wait_state(input logic [2:0] st, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk_i);
            if (state_o == st) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        n_checks++;
        if (gnt_bo !== 4'b0000 || ack_bo !== 4'b0000 || err_bo !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: gnt=%b ack=%b err=%b, want 0000 0000 0", gnt_bo, ack_bo, err_bo);
        end
        n_checks++;
        if (rdata_bo !== 8'h00 || drv_data_o !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: rdata=%h drv_data=%h, want 00 00", rdata_bo, drv_data_o);
        end
        n_checks++;
        if (drv_start_o !== 1'b0 || state_o !== E_IDLE) begin
            n_fail++;
            $display("FAIL reset_fsm: start=%b state=%0d, want 0 0", drv_start_o, state_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        int cyc;
        apply_reset();
        use_fixed       = 1'b1;
        fixed_rx        = 8'h3C;
        wdata_bi[7:0]   = 8'hA5;
        req_bi          = 4'b0001;
        @(negedge clk_i);
        n_checks++;
        if (gnt_bo !== 4'b0001 || drv_start_o !== 1'b1 || drv_data_o !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_start: gnt=%b start=%b data=%h, want 0001 1 a5", gnt_bo, drv_start_o, drv_data_o);
        end
        wdata_bi[7:0] = 8'hFF;
        @(negedge clk_i);
        n_checks++;
        if (drv_start_o !== 1'b0 || drv_data_o !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_hold: start=%b data=%h, want 0 a5", drv_start_o, drv_data_o);
        end
        wait_ack(ok, cyc);
        n_checks++;
        if (!ok || ack_bo !== 4'b0001 || err_bo !== 1'b0 || rdata_bo !== 8'h3C) begin
            n_fail++;
            $display("FAIL single_ack: seen=%0d ack=%b err=%b rdata=%h, want 1 0001 0 3c", ok, ack_bo, err_bo, rdata_bo);
        end
        req_bi = '0;
        @(negedge clk_i);
        n_checks++;
        if (ack_bo !== 4'b0000 || gnt_bo !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_release: ack=%b gnt=%b, want 0000 0000", ack_bo, gnt_bo);
        end
        use_fixed = 1'b0;
    endtask

    task automatic test_contention();
        bit ok;
        int cyc;
        int g;
        logic [N-1:0] eg;
        logic [7:0]   ed;
        apply_reset();
        wdata_bi = {8'h44, 8'h33, 8'h22, 8'h11};
        req_bi   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            g     = k % N;
            eg    = '0;
            eg[g] = 1'b1;
            ed    = 8'(8'h11 * (g + 1));
            wait_start(ok);
            n_checks++;
            if (!ok || gnt_bo !== eg || drv_data_o !== ed) begin
                n_fail++;
                $display("FAIL contention_gnt%0d: seen=%0d gnt=%b data=%h, want %b %h", k, ok, gnt_bo, drv_data_o, eg, ed);
            end
            wait_ack(ok, cyc);
            n_checks++;
            if (!ok || ack_bo !== eg || rdata_bo !== ~ed) begin
                n_fail++;
                $display("FAIL contention_ack%0d: seen=%0d ack=%b rdata=%h, want %b %h", k, ok, ack_bo, rdata_bo, eg, ~ed);
            end
        end
        req_bi = '0;
    endtask

    task automatic test_burst();
        bit ok;
        int cyc;
        apply_reset();
        wdata_bi[7:0]   = 8'h5A;
        wdata_bi[23:16] = 8'hC3;
        lock_bi         = 4'b0001;
        req_bi          = 4'b0101;
        wait_start(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL burst_first_start: no start within bound");
        end
        for (int k = 0; k < MB; k++) begin
            n_checks++;
            if (gnt_bo !== 4'b0001 || drv_data_o !== 8'h5A) begin
                n_fail++;
                $display("FAIL burst_gnt%0d: gnt=%b data=%h, want 0001 5a", k, gnt_bo, drv_data_o);
            end
            wait_ack(ok, cyc);
            n_checks++;
            if (!ok || ack_bo !== 4'b0001 || rdata_bo !== 8'hA5) begin
                n_fail++;
                $display("FAIL burst_ack%0d: seen=%0d ack=%b rdata=%h, want 0001 a5", k, ok, ack_bo, rdata_bo);
            end
            if (k < MB - 1) begin
                @(negedge clk_i);
                n_checks++;
                if (drv_start_o !== 1'b1 || state_o !== E_START) begin
                    n_fail++;
                    $display("FAIL burst_no_idle%0d: start=%b state=%0d, want 1 1", k, drv_start_o, state_o);
                end
            end
        end
        wait_start(ok);
        n_checks++;
        if (!ok || gnt_bo !== 4'b0100 || drv_data_o !== 8'hC3) begin
            n_fail++;
            $display("FAIL burst_release: seen=%0d gnt=%b data=%h, want 0100 c3", ok, gnt_bo, drv_data_o);
        end
        wait_ack(ok, cyc);
        n_checks++;
        if (!ok || ack_bo !== 4'b0100 || rdata_bo !== 8'h3C) begin
            n_fail++;
            $display("FAIL burst_ack2: seen=%0d ack=%b rdata=%h, want 0100 3c", ok, ack_bo, rdata_bo);
        end
        req_bi  = '0;
        lock_bi = '0;
    endtask

    task automatic test_timeout();
        bit ok;
        int cyc;
        apply_reset();
        wdata_bi[31:24] = 8'h77;
        req_bi          = 4'b1000;
        wait_start(ok);
        wait_ack(ok, cyc);
        n_checks++;
        if (!ok || rdata_bo !== 8'h88) begin
            n_fail++;
            $display("FAIL timeout_prep: seen=%0d rdata=%h, want 88", ok, rdata_bo);
        end
        req_bi = '0;
        @(negedge clk_i);
        model_en = 1'b0;
        req_bi   = 4'b1000;
        wait_start(ok);
        wait_ack(ok, cyc);
        n_checks++;
        if (!ok || cyc != BT + 1 || ack_bo !== 4'b1000 || err_bo !== 1'b1 || rdata_bo !== 8'h88) begin
            n_fail++;
            $display("FAIL timeout_ack: seen=%0d cycles=%0d ack=%b err=%b rdata=%h, want 5 1000 1 88",
                     ok, cyc, ack_bo, err_bo, rdata_bo);
        end
        req_bi = '0;
        @(negedge clk_i);
        n_checks++;
        if (state_o !== E_IDLE || err_bo !== 1'b0 || ack_bo !== 4'b0000) begin
            n_fail++;
            $display("FAIL timeout_idle: state=%0d err=%b ack=%b, want 0 0 0000", state_o, err_bo, ack_bo);
        end
        model_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit bad;
        int cyc;
        apply_reset();
        wdata_bi[15:8] = 8'h21;
        req_bi         = 4'b0010;
        wait_start(ok);
        wait_state(E_WAIT_DONE, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rstmid_reach: WAIT_DONE not reached, state=%0d", state_o);
        end
        hold_busy = 1'b1;
        rst_i     = 1'b1;
        #1;
        n_checks++;
        if (gnt_bo !== '0 || ack_bo !== '0 || err_bo !== 1'b0 || rdata_bo !== 8'h00 ||
            drv_start_o !== 1'b0 || drv_data_o !== 8'h00 || state_o !== E_IDLE) begin
            n_fail++;
            $display("FAIL rstmid_async: gnt=%b ack=%b err=%b rdata=%h start=%b data=%h state=%0d, want all 0",
                     gnt_bo, ack_bo, err_bo, rdata_bo, drv_start_o, drv_data_o, state_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        bad   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (drv_start_o !== 1'b0 || gnt_bo !== '0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL rstmid_hold: start or grant while driver busy, got bad=1 want 0");
        end
        hold_busy = 1'b0;
        wait_start(ok);
        n_checks++;
        if (!ok || gnt_bo !== 4'b0010 || drv_data_o !== 8'h21) begin
            n_fail++;
            $display("FAIL rstmid_serve: seen=%0d gnt=%b data=%h, want 0010 21", ok, gnt_bo, drv_data_o);
        end
        wait_ack(ok, cyc);
        n_checks++;
        if (!ok || ack_bo !== 4'b0010 || rdata_bo !== 8'hDE) begin
            n_fail++;
            $display("FAIL rstmid_ack: seen=%0d ack=%b rdata=%h, want 0010 de", ok, ack_bo, rdata_bo);
        end
        req_bi = '0;
    endtask

    task automatic test_withdraw();
        bit ok;
        bit bad;
        int cyc;
        apply_reset();
        wdata_bi[15:8] = 8'h4B;
        lock_bi        = 4'b0010;
        req_bi         = 4'b0010;
        wait_start(ok);
        wait_state(E_WAIT_DONE, ok);
        req_bi = '0;
        wait_ack(ok, cyc);
        n_checks++;
        if (!ok || ack_bo !== 4'b0010 || rdata_bo !== 8'hB4) begin
            n_fail++;
            $display("FAIL withdraw_ack: seen=%0d ack=%b rdata=%h, want 0010 b4", ok, ack_bo, rdata_bo);
        end
        @(negedge clk_i);
        n_checks++;
        if (drv_start_o !== 1'b0 || gnt_bo !== 4'b0000 || state_o !== E_IDLE) begin
            n_fail++;
            $display("FAIL withdraw_release: start=%b gnt=%b state=%0d, want 0 0000 0", drv_start_o, gnt_bo, state_o);
        end
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (drv_start_o !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL withdraw_no_restart: extra start seen, got 1 want 0");
        end
        lock_bi = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_burst();
        test_timeout();
        test_reset_mid();
        test_withdraw();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
